// File: rtl/usb_tx_ll_pkg.sv
// Shared full-speed USB line definitions, common to the transmit and receive
// low-level stages: line symbols, bit timing and bit-stuffing limits.
package usb_tx_ll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP
  } tx_state_e;

  // Line symbols as {dp, dn}
  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  localparam int unsigned CLKS_PER_BIT = 4;
  localparam logic [1:0]  PHASE_LAST   = 2'(CLKS_PER_BIT - 1);

  localparam logic [2:0] STUFF_LIMIT = 3'd6;

  // SYNC is K J K J K J K K; bit i set means period i is K.
  localparam logic [7:0] SYNC_K_MASK = 8'b1101_0101;
  localparam logic [2:0] SYNC_LAST   = 3'd7;
  localparam logic [2:0] EOP_LAST    = 3'd2;

  // NRZI: a 0 toggles between J and K, a 1 holds the current level.
  function automatic logic [1:0] nrzi_next(input logic [1:0] sym, input logic data_bit);
    return data_bit ? sym : {sym[0], sym[1]};
  endfunction

endpackage

// File: rtl/usb_tx_ll.sv
// Full-speed USB low-level transmitter: SYNC generation, NRZI encoding with
// bit stuffing and EOP, driving the PHY pins at 4 clocks per bit.
module usb_tx_ll
  import usb_tx_ll_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic phy_tx_dp,
  output logic phy_tx_dn,
  output logic phy_tx_en,
  input  logic ll_start,
  input  logic ll_bit,
  input  logic ll_last,
  output logic ll_ack,
  output logic ll_busy
);

  tx_state_e  state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] ones_q, ones_d;
  logic       last_q, last_d;
  logic [1:0] sym_q, sym_d;
  logic       en_q, en_d;

  logic       period_end;
  logic       stuff_due;
  logic [2:0] idx_inc;
  logic [1:0] data_sym;
  logic [2:0] data_ones;

  assign period_end = (phase_q == PHASE_LAST);
  assign stuff_due  = (ones_q == STUFF_LIMIT);
  assign idx_inc    = idx_q + 3'd1;
  assign data_sym   = nrzi_next(sym_q, ll_bit);
  assign data_ones  = ll_bit ? (ones_q + 3'd1) : 3'd0;

  // A data bit is requested at the end of every period that is followed by one:
  // the last SYNC period, or a data period that neither owes a stuff bit nor ends the packet.
  assign ll_ack  = period_end &&
                   (((state_q == ST_SYNC) && (idx_q == SYNC_LAST)) ||
                    ((state_q == ST_DATA) && !stuff_due && !last_q));
  assign ll_busy = (state_q != ST_IDLE);

  assign phy_tx_dp = sym_q[1];
  assign phy_tx_dn = sym_q[0];
  assign phy_tx_en = en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= 2'd0;
      idx_q   <= 3'd0;
      ones_q  <= 3'd0;
      last_q  <= 1'b0;
      sym_q   <= SYM_J;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      last_q  <= last_d;
      sym_q   <= sym_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = (state_q == ST_IDLE) ? 2'd0 : phase_q + 2'd1;
    idx_d   = idx_q;
    ones_d  = ones_q;
    last_d  = last_q;
    sym_d   = sym_q;
    en_d    = en_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ll_start) begin
          state_d = ST_SYNC;
          idx_d   = 3'd0;
          ones_d  = 3'd1;
          last_d  = 1'b0;
          sym_d   = SYM_K;
          en_d    = 1'b1;
        end
      end

      ST_SYNC: begin
        if (period_end) begin
          if (idx_q == SYNC_LAST) begin
            state_d = ST_DATA;
            sym_d   = data_sym;
            ones_d  = data_ones;
            last_d  = ll_last;
          end else begin
            idx_d = idx_inc;
            sym_d = SYNC_K_MASK[idx_inc] ? SYM_K : SYM_J;
          end
        end
      end

      ST_DATA: begin
        if (period_end) begin
          if (stuff_due) begin
            sym_d  = {sym_q[0], sym_q[1]};
            ones_d = 3'd0;
          end else if (last_q) begin
            state_d = ST_EOP;
            idx_d   = 3'd0;
            sym_d   = SYM_SE0;
          end else begin
            sym_d  = data_sym;
            ones_d = data_ones;
            last_d = ll_last;
          end
        end
      end

      ST_EOP: begin
        if (period_end) begin
          if (idx_q == EOP_LAST) begin
            state_d = ST_IDLE;
            idx_d   = 3'd0;
            ones_d  = 3'd0;
            last_d  = 1'b0;
            sym_d   = SYM_J;
            en_d    = 1'b0;
          end else begin
            idx_d = idx_inc;
            sym_d = (idx_q == 3'd1) ? SYM_J : SYM_SE0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        sym_d   = SYM_J;
        en_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_tx_ll.sv
// Bench for usb_tx_ll: period-level line model checked every cycle, NRZI/destuff
// loopback decode of the observed line, and literal pins for the directed packets.
module tb_usb_tx_ll;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ll_start = 1'b0;
  logic ll_bit = 1'b0;
  logic ll_last = 1'b0;
  logic phy_tx_dp, phy_tx_dn, phy_tx_en, ll_ack, ll_busy;

  int errors = 0;
  int checks = 0;

  logic       tx_bits[64];
  int         tx_n;
  logic [1:0] obs_sym[$];
  int         ack_cyc[$];
  int         en_cnt;

  usb_tx_ll dut (
    .clk       (clk),
    .rst       (rst),
    .phy_tx_dp (phy_tx_dp),
    .phy_tx_dn (phy_tx_dn),
    .phy_tx_en (phy_tx_en),
    .ll_start  (ll_start),
    .ll_bit    (ll_bit),
    .ll_last   (ll_last),
    .ll_ack    (ll_ack),
    .ll_busy   (ll_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int n, input logic [63:0] v);
    tx_n = n;
    for (int i = 0; i < 64; i++) tx_bits[i] = (i < n) ? v[i] : 1'b0;
  endtask

  function automatic logic [1:0] swap(input logic [1:0] s);
    return {s[0], s[1]};
  endfunction

  // start_mode: 0 = one-cycle start pulse, 1 = hold start through the end
  // (chains the next packet), 2 = hold start but drop it in the final cycle.
  task automatic run_packet(input int start_mode, input bit chained, input int abort_at);
    logic [1:0] per_sym[$];
    bit         per_data[$];
    logic [1:0] lvl;
    logic [1:0] exp_sym;
    logic [1:0] cur;
    int         ones;
    int         nper;
    int         idx;
    bit         prev_ack;
    bit         exp_ack;
    bit         exp_en;

    for (int i = 0; i < 8; i++) begin
      per_sym.push_back((i % 2 == 0 || i == 7) ? K : J);
      per_data.push_back(1'b0);
    end
    lvl  = K;
    ones = 1;
    for (int i = 0; i < tx_n; i++) begin
      if (!tx_bits[i]) lvl = swap(lvl);
      per_sym.push_back(lvl);
      per_data.push_back(1'b1);
      ones = tx_bits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        lvl = swap(lvl);
        per_sym.push_back(lvl);
        per_data.push_back(1'b0);
        ones = 0;
      end
    end
    per_sym.push_back(SE0); per_data.push_back(1'b0);
    per_sym.push_back(SE0); per_data.push_back(1'b0);
    per_sym.push_back(J);   per_data.push_back(1'b0);
    nper = per_sym.size();

    obs_sym.delete();
    ack_cyc.delete();
    en_cnt = 0;
    idx = 0;
    prev_ack = 1'b0;

    if (!chained) begin
      @(posedge clk); #1;
      chk("idle_en", int'(phy_tx_en), 0);
    end
    ll_start = 1'b1;
    ll_bit   = tx_bits[0];
    ll_last  = (tx_n == 1);

    for (int r = 1; r <= 4 * nper + 1; r++) begin
      @(posedge clk); #1;
      if (start_mode == 0 || (start_mode == 2 && r == 4 * nper + 1)) ll_start = 1'b0;
      if (prev_ack) begin
        idx++;
        if (idx < tx_n) begin
          ll_bit  = tx_bits[idx];
          ll_last = (idx == tx_n - 1);
        end else begin
          ll_bit  = 1'($urandom_range(0, 1));
          ll_last = 1'($urandom_range(0, 1));
        end
      end
      if (r <= 4 * nper) begin
        exp_sym = per_sym[(r - 1) / 4];
        exp_en  = 1'b1;
        exp_ack = (r % 4 == 0) && (r / 4 < nper) && per_data[r / 4];
      end else begin
        exp_sym = J;
        exp_en  = 1'b0;
        exp_ack = 1'b0;
      end
      cur = {phy_tx_dp, phy_tx_dn};
      chk($sformatf("line@%0d", r), int'(cur), int'(exp_sym));
      chk($sformatf("en@%0d", r), int'(phy_tx_en), int'(exp_en));
      chk($sformatf("busy@%0d", r), int'(ll_busy), int'(exp_en));
      chk($sformatf("ack@%0d", r), int'(ll_ack), int'(exp_ack));
      if (phy_tx_en) en_cnt++;
      if (ll_ack) ack_cyc.push_back(r);
      if ((r - 1) % 4 == 1 && phy_tx_en) obs_sym.push_back(cur);
      prev_ack = ll_ack;
      if (r == abort_at) begin
        rst = 1'b1;
        $display("pkt n=%0d aborted by reset at cycle %0d", tx_n, r);
        return;
      end
    end
    $display("pkt n=%0d periods=%0d acks=%0d en_cycles=%0d", tx_n, nper, ack_cyc.size(), en_cnt);
  endtask

  // Receiver-side view of the observed line: SYNC, NRZI decode, destuff, EOP.
  task automatic loopback_check(input string tag);
    logic [1:0] lvl;
    int         ones;
    int         k;
    int         i;
    int         bad_bits;
    bit         bs_err;
    bit         sync_ok;
    bit         eop_ok;
    bit         b;

    sync_ok = (obs_sym.size() >= 8);
    for (int s = 0; s < 8 && s < obs_sym.size(); s++)
      if (obs_sym[s] !== ((s % 2 == 0 || s == 7) ? K : J)) sync_ok = 1'b0;
    lvl = K; ones = 1; k = 0; bad_bits = 0; bs_err = 1'b0;
    for (i = 8; i < obs_sym.size() && obs_sym[i] != SE0; i++) begin
      if (ones == 6) begin
        if (obs_sym[i] == lvl) bs_err = 1'b1;
        ones = 0;
      end else begin
        b = (obs_sym[i] == lvl);
        if (k >= tx_n || tx_bits[k] !== b) bad_bits++;
        k++;
        ones = b ? ones + 1 : 0;
      end
      lvl = obs_sym[i];
    end
    eop_ok = (i + 2 < obs_sym.size()) && obs_sym[i] == SE0 &&
             obs_sym[i + 1] == SE0 && obs_sym[i + 2] == J;
    chk({tag, "_sync"}, int'(sync_ok), 1);
    chk({tag, "_nbits"}, k, tx_n);
    chk({tag, "_bits"}, bad_bits, 0);
    chk({tag, "_bs_err"}, int'(bs_err), 0);
    chk({tag, "_eop"}, int'(eop_ok), 1);
  endtask

  logic [1:0] lit_ack[19];
  logic [1:0] lit_ones8[9];
  logic [1:0] lit_five[9];
  logic [63:0] rnd;

  initial begin
    lit_ack   = '{K, J, K, J, K, J, K, K, J, J, K, J, J, K, K, K, SE0, SE0, J};
    lit_ones8 = '{K, K, K, K, K, J, J, J, J};
    lit_five  = '{K, K, K, K, K, J, SE0, SE0, J};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dp", int'(phy_tx_dp), 1);
    chk("rst_dn", int'(phy_tx_dn), 0);
    chk("rst_en", int'(phy_tx_en), 0);
    chk("rst_ack", int'(ll_ack), 0);
    chk("rst_busy", int'(ll_busy), 0);
    rst = 1'b0;

    // ACK PID
    load(8, 64'hD2);
    run_packet(0, 1'b0, 0);
    chk("ack_en_cycles", en_cnt, 76);
    chk("ack_nacks", ack_cyc.size(), 8);
    chk("ack_first", ack_cyc.size() > 0 ? ack_cyc[0] : -1, 32);
    chk("ack_span", ack_cyc.size() == 8 ? ack_cyc[7] - ack_cyc[0] : -1, 28);
    for (int i = 0; i < 19; i++)
      chk($sformatf("ack_sym%0d", i), i < obs_sym.size() ? int'(obs_sym[i]) : -1, int'(lit_ack[i]));
    loopback_check("ack");

    // Eight 1 bits: one stuff bit after the 5th
    load(8, 64'hFF);
    run_packet(0, 1'b0, 0);
    chk("ones8_nacks", ack_cyc.size(), 8);
    chk("ones8_gap5", ack_cyc.size() == 8 ? ack_cyc[5] - ack_cyc[4] : -1, 8);
    chk("ones8_gap4", ack_cyc.size() == 8 ? ack_cyc[4] - ack_cyc[3] : -1, 4);
    chk("ones8_en_cycles", en_cnt, 80);
    for (int i = 0; i < 9; i++)
      chk($sformatf("ones8_sym%0d", i), i + 8 < obs_sym.size() ? int'(obs_sym[i + 8]) : -1, int'(lit_ones8[i]));
    loopback_check("ones8");

    // Five 1 bits ending the packet: pending stuff bit precedes EOP
    load(5, 64'h1F);
    run_packet(0, 1'b0, 0);
    chk("five_en_cycles", en_cnt, 68);
    chk("five_nacks", ack_cyc.size(), 5);
    for (int i = 0; i < 9; i++)
      chk($sformatf("five_sym%0d", i), i + 8 < obs_sym.size() ? int'(obs_sym[i + 8]) : -1, int'(lit_five[i]));
    loopback_check("five");

    // ll_start held high across two back-to-back packets
    load(8, 64'hD2);
    run_packet(1, 1'b0, 0);
    chk("b2b_first_en", en_cnt, 76);
    load(8, 64'hFF);
    run_packet(2, 1'b1, 0);
    chk("b2b_second_en", en_cnt, 80);
    loopback_check("b2b");
    @(posedge clk); #1;
    chk("b2b_no_third", int'(phy_tx_en), 0);

    // Reset during DATA, then a clean packet
    load(16, 64'hA5C3);
    run_packet(0, 1'b0, 45);
    @(posedge clk); #1;
    chk("mid_rst_dp", int'(phy_tx_dp), 1);
    chk("mid_rst_dn", int'(phy_tx_dn), 0);
    chk("mid_rst_en", int'(phy_tx_en), 0);
    chk("mid_rst_busy", int'(ll_busy), 0);
    chk("mid_rst_ack", int'(ll_ack), 0);
    rst = 1'b0;
    load(8, 64'hD2);
    run_packet(0, 1'b0, 0);
    chk("post_rst_en", en_cnt, 76);
    for (int i = 0; i < 8; i++)
      chk($sformatf("post_rst_sync%0d", i), i < obs_sym.size() ? int'(obs_sym[i]) : -1, int'(lit_ack[i]));
    loopback_check("post_rst");

    // Random payloads biased towards runs of 1s
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 64; i++) rnd[i] = ($urandom_range(0, 3) != 0);
      load(int'($urandom_range(1, 64)), rnd);
      run_packet(0, 1'b0, 0);
      loopback_check($sformatf("rnd%0d", p));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
